host_rd_arbiter: RTL and testbench
==================================

# host_rd_arbiter

Arbitrates the single host-SPI readback path between three bulk-read requesters: GPS (0), RX audio (1) and waterfall (2). For each request it grants one source, emits a header word, then issues `len` one-cycle read strobes to that source, forwarding each returned word to the SPI shifter under a credit handshake. It sits between the source `*_rd`/`*_dout` pairs and the HOST shifter, all in the cpu_clk domain.

## Interface
- `LEN_BITS`, 12: width of the per-source burst length register (max burst = 2^LEN_BITS-1 words).
- `cpu_clk` input 1: the only clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous to cpu_clk, active-high.
- `req` input 3: per-source level request, bit i = source i.
- `cfg_we` input 1: strobe; writes `cfg_len` into the length register selected by `cfg_sel`.
- `cfg_sel` input 2: length register select 0..2 (3 ignored).
- `cfg_len` input LEN_BITS: burst length value.
- `src_dout` input 3×16: packed data, source i on bits [16i+15:16i]; valid the cycle after its `rd` strobe.
- `out_ready` input 1: shifter has room for one word arriving next cycle, counting words already in flight.
- `rd` output 3: one-hot read strobe to the granted source.
- `out_valid` output 1: `out_data` holds a word this cycle.
- `out_data` output 16: header or data word.
- `grant` output 3: one-hot current owner, 0 when idle.
- `done` output 3: one-cycle completion pulse per source.
- `busy` output 1: state ≠ IDLE.

## Operation
- Length registers: 3 × LEN_BITS, reset to 0. A `cfg_we` write takes effect at the next grant; it never changes a burst already in progress.
- States: IDLE, HDR, XFER.
- IDLE: if `req` ≠ 0, choose the winner round-robin, starting from the source after `last`. Latch `sel`, load `rem` = len[sel], set `grant`, go to HDR. `last` resets to 2, so source 0 wins first.
- HDR: when `out_ready` is high, issue the header. The next cycle `out_valid`=1 and `out_data` = {sel[1:0], 2'b00, len[11:0]}, with length zero-extended or truncated to 12 bits. Then go to XFER, or straight to IDLE with a `done` pulse if `rem`=0.
- XFER: each cycle that `out_ready` is high and `rem`>0, pulse `rd[sel]` and decrement `rem`. The next cycle `out_valid`=1 and `out_data` = src_dout[sel]. When the strobe that takes `rem` to 0 is issued, go to IDLE; `done[sel]` pulses in the cycle its final word is valid.
- `req` is sampled only in IDLE. Dropping `req` mid-burst does not abort the burst. A source still requesting after `done` is re-arbitrated normally.
- `out_ready` low stalls HDR/XFER indefinitely; there is no timeout.
- `rd` is never asserted outside XFER or to a non-granted source.
- `rst` mid-burst: return to IDLE and clear `rem`, `grant`, `done`, `rd` and `out_valid`. The in-flight word is dropped. Length registers reset to 0.

## Timing
- Reset values: `rd`=0, `out_valid`=0, `out_data`=0, `grant`=0, `done`=0, `busy`=0.
- Request to grant: `req` high in IDLE at cycle t gives `grant`/`busy` high from t+1.
- Header: with `out_ready` high continuously, the header is valid at t+2, the first `rd` is at t+2, and the first data word is valid at t+3.
- Throughput: one word per cycle while `out_ready` is held high.
- `rd` and `out_ready` are combinational in XFER. `out_valid` is `rd`/header-issue registered by one cycle. `out_data` is a mux driven by the registered `sel` and header flag.
- Burst of N ≥ 1 words, `out_ready` held high: the burst occupies N+2 cycles from grant to the `done` pulse. The next grant can occur the cycle after the burst returns to IDLE.
- A `cfg_we` write in the same cycle as an IDLE grant to the same source: the old length is used.

## Configuration
- `HOST_ARB_GPS_PRIO_EN` defined: source 0 (GPS) has strict priority in IDLE; sources 1 and 2 round-robin only when `req[0]`=0.
- `HOST_ARB_GPS_PRIO_EN` undefined: plain 3-way round-robin.

## Test plan
- len[1]=4, `req`=3'b010, `out_ready`=1:
  - header 16'h4004 at t+2;
  - `rd[1]` for 4 consecutive cycles;
  - 4 data words matching the source pattern;
  - `done[1]` with the 4th word;
  - `busy` low the next cycle.
- All sources requesting continuously, lengths 2/2/2: grants go 0,1,2,0. With `HOST_ARB_GPS_PRIO_EN` defined, grants go 0,0,0…
- len[2]=3, `out_ready` toggling 1,0,1,0: `rd` is asserted only in cycles where `out_ready`=1, with exactly 3 strobes and 3 valid words and no duplicates.
- len[0]=0, `req[0]`=1: header 16'h0000 is sent, `done[0]` pulses in the same cycle, and no `rd` strobe occurs.
- len[1]=8, `rst` pulsed after the 3rd `rd`: all outputs are 0 the next cycle, and a subsequent `req[1]` with len re-written to 8 yields a full fresh header plus 8 words.
- `cfg_we` writing len[0]=5 during a 2-word source-0 burst: that burst ends after 2 words, and the next source-0 burst carries header 16'h0005 and 5 words.

Source files
------------

// File: rtl/host_rd_arbiter.sv
// Host SPI readback arbiter: round-robin over GPS/RX audio/waterfall, header word then len data words.
// Define HOST_ARB_GPS_PRIO_EN to give source 0 (GPS) strict priority over sources 1 and 2.
module host_rd_arbiter #(
    parameter int LEN_BITS = 12
) (
    input  logic                      cpu_clk,
    input  logic                      rst,
    input  logic [2:0]                req,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_sel,
    input  logic [LEN_BITS-1:0]       cfg_len,
    input  logic [2:0][15:0]          src_dout,
    input  logic                      out_ready,
    output logic [2:0]                rd,
    output logic                      out_valid,
    output logic [15:0]               out_data,
    output logic [2:0]                grant,
    output logic [2:0]                done,
    output logic                      busy
);
    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;

    state_t                           state;
    logic [NUM_SRC-1:0][LEN_BITS-1:0] len_q;
    logic [1:0]                       sel, last, win;
    logic [LEN_BITS-1:0]              rem, blen;
    logic [2:0]                       sel_oh;
    logic                             hdr_go, rd_go, hdr_q;

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_len
            always_ff @(posedge cpu_clk) begin
                if (rst)
                    len_q[i] <= '0;
                else if (cfg_we && cfg_sel == 2'(i))
                    len_q[i] <= cfg_len;
            end
        end
    endgenerate

    always_comb begin
        win = 2'd0;
`ifdef HOST_ARB_GPS_PRIO_EN
        if (req[0])
            win = 2'd0;
        else if (last == 2'd1)
            win = req[2] ? 2'd2 : 2'd1;
        else
            win = req[1] ? 2'd1 : 2'd2;
`else
        case (last)
            2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
`endif
    end

    assign sel_oh = 3'b001 << sel;
    assign hdr_go = (state == HDR) && out_ready;
    // rem is never 0 in XFER, but the guard keeps rd safe against a stray state
    assign rd_go  = (state == XFER) && out_ready && (rem != '0);
    assign rd     = rd_go ? sel_oh : 3'b000;
    assign busy   = (state != IDLE);

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'd0;
            last      <= 2'd2;
            rem       <= '0;
            blen      <= '0;
            grant     <= 3'b000;
            done      <= 3'b000;
            out_valid <= 1'b0;
            hdr_q     <= 1'b0;
        end else begin
            out_valid <= hdr_go | rd_go;
            hdr_q     <= hdr_go;
            done      <= 3'b000;
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        sel   <= win;
                        last  <= win;
                        rem   <= len_q[win];
                        blen  <= len_q[win];
                        grant <= 3'b001 << win;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        if (rem == '0) begin
                            state <= IDLE;
                            grant <= 3'b000;
                            done  <= sel_oh;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (rd_go) begin
                        rem <= rem - LEN_BITS'(1);
                        // done lands with the last word, one cycle after its strobe
                        if (rem == LEN_BITS'(1)) begin
                            state <= IDLE;
                            grant <= 3'b000;
                            done  <= sel_oh;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = 16'h0000;
        if (out_valid)
            out_data = hdr_q ? {sel, 2'b00, 12'(blen)} : src_dout[sel];
    end

endmodule

// File: tb/tb_host_rd_arbiter.sv
// Directed bench for host_rd_arbiter: bursts, round-robin order, stalls, zero length, reset, cfg timing.
module tb_host_rd_arbiter;
    logic             cpu_clk;
    logic             rst;
    logic [2:0]       req;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [11:0]      cfg_len;
    logic [2:0][15:0] src_dout;
    logic             out_ready;
    logic [2:0]       rd;
    logic             out_valid;
    logic [15:0]      out_data;
    logic [2:0]       grant;
    logic [2:0]       done;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int unsigned scnt [3];

    host_rd_arbiter #(.LEN_BITS(12)) dut (
        .cpu_clk(cpu_clk), .rst(rst), .req(req), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_len(cfg_len), .src_dout(src_dout), .out_ready(out_ready), .rd(rd),
        .out_valid(out_valid), .out_data(out_data), .grant(grant), .done(done), .busy(busy)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Source model: word = D000 | src<<8 | running count, valid the cycle after rd
    always @(posedge cpu_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst)
                scnt[i] <= 0;
            else if (rd[i]) begin
                src_dout[i] <= 16'hD000 | (16'(i) << 8) | 16'(scnt[i]);
                scnt[i]     <= scnt[i] + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge cpu_clk);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1; req = 3'b000; cfg_we = 1'b0; out_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("reset_outs", {rd, out_valid, out_data, grant, done, busy}, 32'd0);
    endtask

    task automatic cfg(input int s, input int n);
        cyc();
        cfg_we = 1'b1; cfg_sel = 2'(s); cfg_len = 12'(n);
        cyc();
        cfg_we = 1'b0;
    endtask

    // wmode: 0 none, 1 cfg write in the grant cycle, 2 cfg write at the first rd cycle
    task automatic run_burst(input int s, input int n, input int c0, input int wmode, input int wlen);
        logic [2:0]  oh;
        logic [15:0] h;
        oh = 3'b001 << s;
        h  = {2'(s), 2'b00, 12'(n)};
        cyc();
        req = oh;
        if (wmode == 1) begin cfg_we = 1'b1; cfg_sel = 2'(s); cfg_len = 12'(wlen); end
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        cyc();
        req = 3'b000; cfg_we = 1'b0;
        #1;
        chk("grant", 32'(grant), 32'(oh));
        chk("hdr_busy", 32'(busy), 32'd1);
        chk("hdr_rd", 32'(rd), 32'd0);
        chk("hdr_nvalid", 32'(out_valid), 32'd0);
        cyc();
        if (wmode == 2) begin cfg_we = 1'b1; cfg_sel = 2'(s); cfg_len = 12'(wlen); end
        #1;
        chk("hdr_valid", 32'(out_valid), 32'd1);
        chk("hdr_word", 32'(out_data), 32'(h));
        chk("rd_first", 32'(rd), (n > 0) ? 32'(oh) : 32'd0);
        chk("hdr_done", 32'(done), (n == 0) ? 32'(oh) : 32'd0);
        chk("hdr_busy2", 32'(busy), (n == 0) ? 32'd0 : 32'd1);
        for (int k = 0; k < n; k++) begin
            cyc();
            cfg_we = 1'b0;
            #1;
            chk("dat_valid", 32'(out_valid), 32'd1);
            chk("dat_word", 32'(out_data), 32'(16'hD000 | (16'(s) << 8) | 16'(c0 + k)));
            chk("dat_rd", 32'(rd), (k < n - 1) ? 32'(oh) : 32'd0);
            chk("dat_done", 32'(done), (k == n - 1) ? 32'(oh) : 32'd0);
            chk("dat_busy", 32'(busy), (k == n - 1) ? 32'd0 : 32'd1);
        end
        cyc();
        cfg_we = 1'b0;
        #1;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2:0]  rr_exp [4];
        logic [15:0] words [$];
        int          nrd;

        rst = 1'b1; req = 3'b000; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_len = 12'd0; out_ready = 1'b1;

        // basic 4-word burst from source 1, header 16'h4004
        do_reset();
        cfg(1, 4);
        run_burst(1, 4, 0, 0, 0);

        // all requesting, 2/2/2 lengths: one grant every 4 cycles
        do_reset();
        cfg(0, 2); cfg(1, 2); cfg(2, 2);
`ifdef HOST_ARB_GPS_PRIO_EN
        rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        cyc();
        req = 3'b111;
        cyc();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 32'(grant), 32'(rr_exp[k]));
            repeat (4) cyc();
        end
        req = 3'b000;

        // out_ready toggling on a 3-word source-2 burst
        do_reset();
        cfg(2, 3);
        cyc();
        req = 3'b100; out_ready = 1'b1;
        cyc();
        req = 3'b000;
        nrd = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) cyc();
            out_ready = (i % 2 == 0);
            #1;
            chk("rd_gate", 32'(rd & ~(out_ready ? 3'b100 : 3'b000)), 32'd0);
            if (rd != 3'b000) nrd++;
            if (out_valid) words.push_back(out_data);
        end
        out_ready = 1'b1;
        chk("stall_nrd", 32'(nrd), 32'd3);
        chk("stall_nwords", 32'(words.size()), 32'd4);
        if (words.size() >= 4) begin
            chk("stall_hdr", 32'(words[0]), 32'h8003);
            chk("stall_w0", 32'(words[1]), 32'hD200);
            chk("stall_w1", 32'(words[2]), 32'hD201);
            chk("stall_w2", 32'(words[3]), 32'hD202);
        end

        // zero length: header 0000 with done, no strobe
        do_reset();
        run_burst(0, 0, 0, 0, 0);

        // reset mid-burst after the third strobe, then a fresh 8-word burst
        do_reset();
        cfg(1, 8);
        cyc();
        req = 3'b010;
        cyc();
        req = 3'b000;
        cyc();
        #1;
        chk("abort_rd1", 32'(rd), 32'h2);
        cyc();
        #1;
        chk("abort_rd2", 32'(rd), 32'h2);
        cyc();
        rst = 1'b1;
        #1;
        chk("abort_rd3", 32'(rd), 32'h2);
        cyc();
        rst = 1'b0;
        #1;
        chk("abort_outs", {rd, out_valid, out_data, grant, done, busy}, 32'd0);
        cfg(1, 8);
        run_burst(1, 8, 0, 0, 0);

        // cfg writes never touch a burst in progress or being granted
        do_reset();
        cfg(0, 2);
        run_burst(0, 2, 0, 2, 5);
        run_burst(0, 5, 2, 0, 0);
        run_burst(0, 5, 7, 1, 3);
        run_burst(0, 3, 12, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
